mem_byte_sequencer: RTL and testbench

//  Sequences one byte-wide synchronous memory (8-bit data, 1-cycle registered read)
//  to serve RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready port.

---
 rtl/mem_byte_sequencer.sv | 159 +++++++++++++++
 tb/tb_mem_byte_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_byte_sequencer.sv
// Byte-serial sequencer between a RISC-V load/store port and an 8-bit synchronous memory.
// Splits LB/LH/LW/LBU/LHU/SB/SH/SW into little-endian byte cycles and extends load data.
module mem_byte_sequencer #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic                  resp_error,
  output logic [31:0]           resp_rdata,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [7:0]            mem_write_data,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic [7:0]            mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [2:0]            funct3_q, funct3_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [2:0]            cnt_q, cnt_d;

  logic                  legal;
  logic                  aligned;
  logic [2:0]            size_n;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           ext_rdata;

  logic                  unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH];

  always_comb begin
    if (req_write) legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else           legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                           (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
    case (req_funct3[1:0])
      2'b01:   aligned = (req_addr[0] == 1'b0);
      2'b10:   aligned = (req_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    case (funct3_q[1:0])
      2'b00:   size_n = 3'd1;
      2'b01:   size_n = 3'd2;
      default: size_n = 3'd4;
    endcase
    cur_addr = base_q + ADDR_WIDTH'(cnt_q);
    case (funct3_q[1:0])
      2'b00:   ext_rdata = funct3_q[2] ? {24'h0, rdata_q[7:0]}  : {{24{rdata_q[7]}}, rdata_q[7:0]};
      2'b01:   ext_rdata = funct3_q[2] ? {16'h0, rdata_q[15:0]} : {{16{rdata_q[15]}}, rdata_q[15:0]};
      default: ext_rdata = rdata_q;
    endcase
  end

  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    wdata_d           = wdata_q;
    rdata_d           = rdata_q;
    funct3_d          = funct3_q;
    write_d           = write_q;
    err_d             = err_q;
    cnt_d             = cnt_q;
    req_ready         = (state_q == IDLE) && !reset;
    resp_valid        = 1'b0;
    resp_error        = 1'b0;
    resp_rdata        = '0;
    mem_write_enable  = 1'b0;
    mem_write_address = '0;
    mem_write_data    = '0;
    mem_read_address  = '0;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          base_d   = req_addr[ADDR_WIDTH-1:0];
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          write_d  = req_write;
          cnt_d    = '0;
          rdata_d  = '0;
          err_d    = !legal || !aligned;
          if (err_d)          state_d = RESP;
          else if (req_write) state_d = WRITE;
          else                state_d = READ;
        end
      end
      WRITE: begin
        mem_write_enable  = 1'b1;
        mem_write_address = cur_addr;
        mem_write_data    = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        cnt_d             = cnt_q + 3'd1;
        if (cnt_q == size_n - 3'd1) state_d = RESP;
      end
      READ: begin
        // Address for byte k goes out while byte k-1 returns, so this state runs N+1 cycles.
        if (cnt_q < size_n) mem_read_address = cur_addr;
        if (cnt_q != 3'd0) rdata_d[{cnt_q[1:0] - 2'd1, 3'b000} +: 8] = mem_read_data;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == size_n) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_error = err_q;
        resp_rdata = (err_q || write_q) ? 32'h0 : ext_rdata;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset must block the write already being presented in the current cycle.
    if (reset) begin
      mem_write_enable  = 1'b0;
      mem_write_address = '0;
      mem_write_data    = '0;
      mem_read_address  = '0;
      resp_valid        = 1'b0;
      resp_error        = 1'b0;
      resp_rdata        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      funct3_q <= funct3_d;
      write_q  <= write_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Directed bench for mem_byte_sequencer with a behavioural 1-cycle-read byte memory.
module tb_mem_byte_sequencer;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_error;
  logic [31:0]   resp_rdata;
  logic          mem_write_enable;
  logic [AW-1:0] mem_write_address;
  logic [7:0]    mem_write_data;
  logic [AW-1:0] mem_read_address;
  logic [7:0]    mem_read_data;

  always #5 clk = ~clk;

  mem_byte_sequencer #(.ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_funct3        (req_funct3),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .resp_valid        (resp_valid),
    .resp_error        (resp_error),
    .resp_rdata        (resp_rdata),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .mem_read_address  (mem_read_address),
    .mem_read_data     (mem_read_data)
  );

  logic [7:0] tb_mem [2**AW];
  logic       mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int unsigned i = 0; i < 2**AW; i++) tb_mem[i] <= '0;
    end else if (mem_write_enable) begin
      tb_mem[mem_write_address] <= mem_write_data;
    end
    mem_read_data <= tb_mem[mem_read_address];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  logic          we_c [12];
  logic [AW-1:0] wa_c [12];
  logic [7:0]    wd_c [12];
  logic [AW-1:0] ra_c [12];
  int            lat;
  logic          rerr;
  logic [31:0]   rdat;

  task automatic issue(input string tag, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = d;
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Records per-cycle memory activity from cycle 1 until the response, bounded at 10 cycles.
  task automatic txn(input string tag, input logic w, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d);
    for (int unsigned i = 0; i < 12; i++) begin
      we_c[i] = 1'b0; wa_c[i] = '0; wd_c[i] = '0; ra_c[i] = '0;
    end
    lat  = 0;
    rerr = 1'b0;
    rdat = '0;
    issue(tag, w, f3, a, d);
    for (int c = 1; c <= 10; c++) begin
      we_c[c] = mem_write_enable;
      wa_c[c] = mem_write_address;
      wd_c[c] = mem_write_data;
      ra_c[c] = mem_read_address;
      if (resp_valid) begin
        lat  = c;
        rerr = resp_error;
        rdat = resp_rdata;
        break;
      end
      @(negedge clk);
    end
  endtask

  logic [7:0] sw_bytes [4];
  int         seen_resp;

  initial begin
    sw_bytes[0] = 8'hEF; sw_bytes[1] = 8'hBE; sw_bytes[2] = 8'hAD; sw_bytes[3] = 8'hDE;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    reset   = 1'b1;
    mem_clr = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_mem_we", 32'(mem_write_enable), 32'd0);
    reset   = 1'b0;
    mem_clr = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);
    check_eq("post_rst_rdata", resp_rdata, 32'h0);
    check_eq("post_rst_rdaddr", 32'(mem_read_address), 32'h0);

    // SW 0x010 <- 0xDEADBEEF
    txn("sw", 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF);
    check_eq("sw_lat", lat, 32'd5);
    check_eq("sw_err", 32'(rerr), 32'd0);
    check_eq("sw_rdata", rdat, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      check_eq($sformatf("sw_we%0d", c), 32'(we_c[c]), 32'd1);
      check_eq($sformatf("sw_wa%0d", c), 32'(wa_c[c]), 32'h10 + 32'(c - 1));
      check_eq($sformatf("sw_wd%0d", c), 32'(wd_c[c]), 32'(sw_bytes[c-1]));
    end
    check_eq("sw_we_resp", 32'(we_c[5]), 32'd0);

    // LW 0x010
    txn("lw", 1'b0, 3'b010, 32'h0000_0010, 32'h0);
    check_eq("lw_lat", lat, 32'd6);
    check_eq("lw_rdata", rdat, 32'hDEAD_BEEF);
    check_eq("lw_err", 32'(rerr), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      check_eq($sformatf("lw_ra%0d", c), 32'(ra_c[c]), 32'h10 + 32'(c - 1));
      check_eq($sformatf("lw_we%0d", c), 32'(we_c[c]), 32'd0);
    end

    txn("lb", 1'b0, 3'b000, 32'h0000_0013, 32'h0);
    check_eq("lb_lat", lat, 32'd3);
    check_eq("lb_rdata", rdat, 32'hFFFF_FFDE);
    txn("lbu", 1'b0, 3'b100, 32'h0000_0013, 32'h0);
    check_eq("lbu_rdata", rdat, 32'h0000_00DE);
    txn("lh", 1'b0, 3'b001, 32'h0000_0012, 32'h0);
    check_eq("lh_lat", lat, 32'd4);
    check_eq("lh_rdata", rdat, 32'hFFFF_DEAD);
    txn("lhu", 1'b0, 3'b101, 32'h0000_0010, 32'h0);
    check_eq("lhu_rdata", rdat, 32'h0000_BEEF);

    // Rejected requests: misaligned LW, store with funct3=100, load with funct3=011
    txn("lw_mis", 1'b0, 3'b010, 32'h0000_0011, 32'h0);
    check_eq("lw_mis_lat", lat, 32'd1);
    check_eq("lw_mis_err", 32'(rerr), 32'd1);
    check_eq("lw_mis_rdata", rdat, 32'h0);
    check_eq("lw_mis_we", 32'(we_c[1]), 32'd0);
    check_eq("lw_mis_ra", 32'(ra_c[1]), 32'd0);
    txn("sb_bad", 1'b1, 3'b100, 32'h0000_0010, 32'h0000_0055);
    check_eq("sb_bad_lat", lat, 32'd1);
    check_eq("sb_bad_err", 32'(rerr), 32'd1);
    check_eq("sb_bad_we", 32'(we_c[1]), 32'd0);
    txn("lw_bad", 1'b0, 3'b011, 32'h0000_0010, 32'h0);
    check_eq("lw_bad_lat", lat, 32'd1);
    check_eq("lw_bad_err", 32'(rerr), 32'd1);

    // SW 0x020 aborted by reset in cycle 2
    issue("sw_rst", 1'b1, 3'b010, 32'h0000_0020, 32'h1122_3344);
    check_eq("sw_rst_we1", 32'(mem_write_enable), 32'd1);
    check_eq("sw_rst_wd1", 32'(mem_write_data), 32'h44);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("sw_rst_we2", 32'(mem_write_enable), 32'd0);
    check_eq("sw_rst_ready_in_rst", 32'(req_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("sw_rst_ready_after", 32'(req_ready), 32'd1);
    seen_resp = 0;
    for (int c = 0; c < 6; c++) begin
      if (resp_valid) seen_resp++;
      @(negedge clk);
    end
    check_eq("sw_rst_no_resp", seen_resp, 32'd0);
    txn("lw_rst", 1'b0, 3'b010, 32'h0000_0020, 32'h0);
    check_eq("lw_rst_rdata", rdat, 32'h0000_0044);

    // SB with upper address bits set lands on byte 0x7FF
    txn("sb_hi", 1'b1, 3'b000, 32'hFFFF_F7FF, 32'h0000_005A);
    check_eq("sb_hi_lat", lat, 32'd2);
    check_eq("sb_hi_wa", 32'(wa_c[1]), 32'h7FF);
    check_eq("sb_hi_wd", 32'(wd_c[1]), 32'h5A);
    txn("lbu_hi", 1'b0, 3'b100, 32'h0000_07FF, 32'h0);
    check_eq("lbu_hi_rdata", rdat, 32'h0000_005A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
